// File: rtl/ram_arbiter.sv
// Round-robin arbiter that lets PORTS requesters share a single ram with separate read and write ports.
// Only one transaction is in flight at a time, and a watchdog aborts any access the ram never acknowledges.
module ram_arbiter #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 16,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PORTS-1:0]       req_valid,
    input  logic [PORTS-1:0]       req_write,
    input  logic [PORTS*AW-1:0]    req_address,
    input  logic [PORTS*WIDTH-1:0] req_wdata,
    output logic [PORTS-1:0]       req_ready,
    output logic [PORTS-1:0]       rsp_valid,
    output logic                   rsp_error,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy,
    output logic                   ram_read_valid,
    input  logic                   ram_read_ready,
    output logic [AW-1:0]          ram_read_address,
    input  logic [WIDTH-1:0]       ram_read_data,
    output logic                   ram_write_valid,
    input  logic                   ram_write_ready,
    output logic [AW-1:0]          ram_write_address,
    output logic [WIDTH-1:0]       ram_write_data
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      grant_q, grant_d;
    logic               op_write_q, op_write_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [PORTS-1:0]   req_ready_q, req_ready_d;
    logic [PORTS-1:0]   rsp_valid_q, rsp_valid_d;
    logic               rsp_error_q, rsp_error_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wr_valid_q, wr_valid_d;

    logic [AW-1:0]      addr_arr  [PORTS];
    logic [WIDTH-1:0]   wdata_arr [PORTS];

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_address[gi*AW +: AW];
        assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
    end

    // Scan from the farthest candidate to the nearest, so the port closest to ptr+1 wins.
    logic          grant_hit;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand;

    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = PORTS; off >= 1; off--) begin
            cand = PW'((int'(ptr_q) + off) % PORTS);
            if (req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

    logic             ram_ack;
    logic             timeout_hit;
    logic [PORTS-1:0] grant_onehot;

    assign ram_ack      = op_write_q ? ram_write_ready : ram_read_ready;
    assign timeout_hit  = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));
    assign grant_onehot = PORTS'(1) << grant_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        timer_d     = timer_q;
        rsp_data_d  = rsp_data_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_error_d = 1'b0;
        rd_valid_d  = rd_valid_q;
        wr_valid_d  = wr_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_hit) begin
                    grant_d    = grant_idx;
                    op_write_d = req_write[grant_idx];
                    addr_d     = addr_arr[grant_idx];
                    wdata_d    = wdata_arr[grant_idx];
                    timer_d    = '0;
                    rd_valid_d = ~req_write[grant_idx];
                    wr_valid_d = req_write[grant_idx];
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // A real acknowledge beats the watchdog when both land on the same edge.
                if (ram_ack) begin
                    if (!op_write_q) begin
                        rsp_data_d  = ram_read_data;
                        rsp_valid_d = grant_onehot;
                    end
                    req_ready_d = grant_onehot;
                    rd_valid_d  = 1'b0;
                    wr_valid_d  = 1'b0;
                    state_d     = DONE;
                end else if (timeout_hit) begin
                    req_ready_d = grant_onehot;
                    rsp_error_d = 1'b1;
                    rd_valid_d  = 1'b0;
                    wr_valid_d  = 1'b0;
                    state_d     = DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                ptr_d   = grant_q;
                timer_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(PORTS - 1);
            grant_q     <= '0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            timer_q     <= '0;
            rsp_data_q  <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_error_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            timer_q     <= timer_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rd_valid_q  <= rd_valid_d;
            wr_valid_q  <= wr_valid_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_error         = rsp_error_q;
    assign rsp_data          = rsp_data_q;
    assign busy              = (state_q != IDLE);
    assign ram_read_valid    = rd_valid_q;
    assign ram_read_address  = addr_q;
    assign ram_write_valid   = wr_valid_q;
    assign ram_write_address = addr_q;
    assign ram_write_data    = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a behavioural ram with programmable ready delay or stall, plus a
// scoreboard monitor that checks every completion against the expected results queue.
module tb_ram_arbiter;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int PORTS   = 4;
    localparam int TIMEOUT = 16;
    localparam int AW      = 3;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [PORTS-1:0]       req_valid;
    logic [PORTS-1:0]       req_write;
    logic [PORTS*AW-1:0]    req_address;
    logic [PORTS*WIDTH-1:0] req_wdata;
    logic [PORTS-1:0]       req_ready;
    logic [PORTS-1:0]       rsp_valid;
    logic                   rsp_error;
    logic [WIDTH-1:0]       rsp_data;
    logic                   busy;
    logic                   ram_read_valid;
    logic                   ram_read_ready;
    logic [AW-1:0]          ram_read_address;
    logic [WIDTH-1:0]       ram_read_data;
    logic                   ram_write_valid;
    logic                   ram_write_ready;
    logic [AW-1:0]          ram_write_address;
    logic [WIDTH-1:0]       ram_write_data;

    always #5 clock = ~clock;

    ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
        .rsp_data(rsp_data), .busy(busy),
        .ram_read_valid(ram_read_valid), .ram_read_ready(ram_read_ready),
        .ram_read_address(ram_read_address), .ram_read_data(ram_read_data),
        .ram_write_valid(ram_write_valid), .ram_write_ready(ram_write_ready),
        .ram_write_address(ram_write_address), .ram_write_data(ram_write_data)
    );

    typedef struct {
        int         port;
        bit         is_read;
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ram model: ready is raised once valid has been seen for ram_delay cycles, and never while stalled.
    logic [7:0]    mem [DEPTH];
    int            ram_delay = 0;
    bit            ram_stall = 1'b0;
    int            wait_cnt  = 0;
    logic          rdy       = 1'b0;
    logic [AW-1:0] saved_addr;
    logic [7:0]    saved_wdata;

    assign ram_read_ready  = rdy;
    assign ram_write_ready = rdy;

    always @(negedge clock) begin
        if (ram_read_valid || ram_write_valid) begin
            chk("one_ram_valid", 32'(ram_read_valid && ram_write_valid), 0);
            if (wait_cnt > 0) begin
                chk("ram_addr_stable", 32'(ram_read_valid ? ram_read_address : ram_write_address),
                    32'(saved_addr));
                if (ram_write_valid) chk("ram_wdata_stable", 32'(ram_write_data), 32'(saved_wdata));
            end
            saved_addr    = ram_read_valid ? ram_read_address : ram_write_address;
            saved_wdata   = ram_write_data;
            ram_read_data = mem[ram_read_address];
            rdy           = !ram_stall && (wait_cnt >= ram_delay);
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            rdy      = 1'b0;
        end
    end

    always @(posedge clock) begin
        if (ram_write_valid && rdy) mem[ram_write_address] <= ram_write_data;
    end

    // Monitor: every completion pulse is matched against the next expected result.
    always @(negedge clock) begin
        if (req_ready != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_completion", 32'(req_ready), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("grant_port", 32'(req_ready), 32'(1) << mon_e.port);
                chk("rsp_error", 32'(rsp_error), 32'(mon_e.err));
                chk("rsp_valid", 32'(rsp_valid),
                    (mon_e.is_read && !mon_e.err) ? (32'(1) << mon_e.port) : 0);
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                chk("busy_in_done", 32'(busy), 1);
                $display("txn port=%0d %s err=%0d rsp_data=0x%02h t=%0t", mon_e.port,
                         mon_e.is_read ? "read " : "write", rsp_error, rsp_data, $time);
            end
        end else if (rsp_valid != '0 || rsp_error) begin
            chk("orphan_response", {27'd0, rsp_valid, rsp_error}, 0);
        end
    end

    task automatic issue(input int p, input bit wr, input logic [AW-1:0] a, input logic [7:0] d);
        req_valid[p]             = 1'b1;
        req_write[p]             = wr;
        req_address[p*AW +: AW]  = a;
        req_wdata[p*WIDTH +: 8]  = d;
    endtask

    task automatic push(input int p, input bit rd, input bit err, input logic [7:0] d);
        exp_t e;
        e.port = p; e.is_read = rd; e.err = err; e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Single transaction: checks how many cycles the ram valid was up and when the completion arrived.
    task automatic run_one(input string name, input int p, input bit wr, input logic [AW-1:0] a,
                           input logic [7:0] d, input int exp_busy, input bit err,
                           input logic [7:0] exp_rsp);
        int busy_cyc = 0;
        int wrong    = 0;
        int elapsed  = 0;
        bit done     = 1'b0;
        @(negedge clock);
        issue(p, wr, a, d);
        push(p, !wr, err, exp_rsp);
        while (!done && elapsed < 100) begin
            @(negedge clock);
            elapsed++;
            if (wr ? ram_write_valid : ram_read_valid) busy_cyc++;
            if (wr ? ram_read_valid : ram_write_valid) wrong++;
            if (req_ready[p]) done = 1'b1;
        end
        req_valid[p] = 1'b0;
        chk({name, "_completed"}, 32'(done), 1);
        chk({name, "_ram_valid_cycles"}, 32'(busy_cyc), 32'(exp_busy));
        chk({name, "_other_valid_cycles"}, 32'(wrong), 0);
        chk({name, "_latency"}, 32'(elapsed), 32'(exp_busy + 1));
    endtask

    // Waits for n completions; optionally drops each requester's valid once it is served.
    task automatic wait_n(input string name, input int n, input bit clear);
        int got     = 0;
        int elapsed = 0;
        while (got < n && elapsed < 300) begin
            @(negedge clock);
            elapsed++;
            if (req_ready != '0) begin
                got++;
                if (clear) req_valid = req_valid & ~req_ready;
            end
        end
        chk({name, "_completions"}, 32'(got), 32'(n));
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {req_ready, rsp_valid, rsp_error, rsp_data, busy, ram_read_valid,
                              ram_write_valid, ram_read_address, ram_write_data}, 0);
        reset = 1'b0;

        run_one("t1_write_p0", 0, 1'b1, 3'd3, 8'hA5, 1, 1'b0, 8'h00);
        run_one("t2_read_p2", 2, 1'b0, 3'd3, 8'h00, 1, 1'b0, 8'hA5);

        // All four ports request continuously right after reset.
        do_reset();
        for (int i = 0; i < PORTS; i++) issue(i, 1'b1, AW'(i + 4), 8'(8'h10 + i));
        push(0, 1'b0, 1'b0, 8'h00);
        push(1, 1'b0, 1'b0, 8'h00);
        push(2, 1'b0, 1'b0, 8'h00);
        push(3, 1'b0, 1'b0, 8'h00);
        push(0, 1'b0, 1'b0, 8'h00);
        wait_n("t3_round_robin", 5, 1'b0);
        req_valid = '0;

        run_one("t3_readback_p3", 3, 1'b0, 3'd5, 8'h00, 1, 1'b0, 8'h11);

        ram_stall = 1'b1;
        run_one("t4_timeout_p1", 1, 1'b0, 3'd0, 8'h00, TIMEOUT, 1'b1, 8'h11);

        // Reset lands while a stalled write is in flight.
        @(negedge clock);
        issue(2, 1'b1, 3'd2, 8'h77);
        repeat (3) @(negedge clock);
        chk("t5_in_flight", 32'(ram_write_valid), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_reset_outputs", {req_ready, rsp_valid, rsp_error, rsp_data, busy, ram_read_valid,
                                 ram_write_valid, ram_read_address, ram_write_data}, 0);
        reset     = 1'b0;
        req_valid = '0;
        ram_stall = 1'b0;
        issue(1, 1'b0, 3'd4, 8'h00);
        issue(0, 1'b1, 3'd6, 8'h66);
        push(0, 1'b0, 1'b0, 8'h00);
        push(1, 1'b1, 1'b0, 8'h10);
        wait_n("t5_after_reset", 2, 1'b1);
        chk("t5_no_requests_left", 32'(req_valid), 0);

        ram_delay = 5;
        run_one("t6_delayed_write_p3", 3, 1'b1, 3'd7, 8'h3C, 6, 1'b0, 8'h10);
        ram_delay = 0;
        run_one("t6_readback_p0", 0, 1'b0, 3'd7, 8'h00, 1, 1'b0, 8'h3C);

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        chk("idle_at_end", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
